// File: rtl/reg_write_arbiter_pkg.sv
// reg_arb_pkg: shared definitions for the register write arbiter.
//   NUM_REQ_DEFAULT  - default number of write requesters
//   GRANT_CNT_WIDTH  - width of each per-requester accepted-write counter
//   arb_state_t      - output register occupancy (EMPTY / FULL)
//   wrap_idx()       - (base + off) mod n, used for round-robin indexing
package reg_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 4;
    localparam int unsigned GRANT_CNT_WIDTH = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// w_busif: write stream toward the register controller's write port.
//   data  - write data
//   addr  - write address
//   valid - write present (driven by master)
//   ready - sink accepts this cycle (driven by slave)
interface w_busif #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  valid;
    logic                  ready;

    modport master (output data, output addr, output valid, input ready);
    modport slave  (input data, input addr, input valid, output ready);

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   i_req   - request vector
//   i_ptr   - index with highest priority this cycle
//   o_grant - one-hot grant (all zero when nothing requests)
//   o_idx   - index of the granted requester
//   o_any   - at least one request present
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan NUM_REQ slots starting at i_ptr, wrapping; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[PTR_W'(wrap_idx(32'(i_ptr), k, NUM_REQ))]) begin
                o_any = 1'b1;
                o_grant[PTR_W'(wrap_idx(32'(i_ptr), k, NUM_REQ))] = 1'b1;
                o_idx = PTR_W'(wrap_idx(32'(i_ptr), k, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges NUM_REQ register write requesters into one
// write stream through a single output register, round-robin fair.
//   clk        - clock, all logic on posedge
//   rstn       - synchronous active-low reset
//   req_data   - per-requester write data
//   req_addr   - per-requester write address
//   req_valid  - per-requester write request
//   req_ready  - per-requester accept (at most one bit high)
//   w_out      - merged write stream (master side)
//   grant_cnt  - per-requester accepted-write counters (wrapping)
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_data,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    w_busif.master                                   w_out,
    output logic [NUM_REQ-1:0][GRANT_CNT_WIDTH-1:0]  grant_cnt
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_t                              r_state;
    arb_state_t                              w_state_nxt;
    logic [PTR_W-1:0]                        r_rr_ptr;
    logic [DATA_WIDTH-1:0]                   r_data;
    logic [ADDR_WIDTH-1:0]                   r_addr;
    logic [NUM_REQ-1:0][GRANT_CNT_WIDTH-1:0] r_grant_cnt;

    logic                                    w_load_en;
    logic                                    w_accept;
    logic                                    w_any;
    logic [NUM_REQ-1:0]                      w_grant;
    logic [PTR_W-1:0]                        w_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Output register can take a new write when empty or draining this cycle.
    assign w_load_en = (r_state == EMPTY) || w_out.ready;
    // rstn gates acceptance so nothing is handshaken during reset.
    assign w_accept  = w_load_en && w_any && rstn;
    assign req_ready = w_accept ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_any)                  w_state_nxt = FULL;
            FULL:  if (w_out.ready && !w_any)  w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data      <= '0;
            r_addr      <= '0;
            r_rr_ptr    <= '0;
            r_grant_cnt <= '0;
        end else if (w_accept) begin
            r_data             <= req_data[w_idx];
            r_addr             <= req_addr[w_idx];
            r_rr_ptr           <= PTR_W'(wrap_idx(32'(w_idx), 1, NUM_REQ));
            r_grant_cnt[w_idx] <= r_grant_cnt[w_idx] + GRANT_CNT_WIDTH'(1);
        end
    end

    assign w_out.data  = r_data;
    assign w_out.addr  = r_addr;
    assign w_out.valid = (r_state == FULL);
    assign grant_cnt   = r_grant_cnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic             clk;
    logic             rstn;
    logic [3:0][31:0] req_data;
    logic [3:0][7:0]  req_addr;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][15:0] grant_cnt;

    w_busif #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    reg_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .w_out     (bus),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the output register is the head of a queue of accepted writes.
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_ptr = 0;
    logic [15:0] m_cnt [4] = '{default: 16'h0};
    int          m_wait[4] = '{default: 0};

    always @(negedge clk) begin : compare
        int   w;
        int   j;
        logic load;
        logic [3:0] exp_rdy;
        ent_t e;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (w < 0 && req_valid[j]) w = j;
        end
        load    = (q.size() == 0) || bus.ready;
        exp_rdy = (rstn && load && w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(bus.data), 64'(q[0].data));
            chk("out_addr", 64'(bus.addr), 64'(q[0].addr));
        end
        for (int i = 0; i < 4; i++) chk("grant_cnt", 64'(grant_cnt[i]), 64'(m_cnt[i]));

        if (!rstn) begin
            q.delete();
            m_ptr = 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = 16'h0;
                m_wait[i] = 0;
            end
        end else begin
            if (q.size() != 0 && bus.ready) void'(q.pop_front());
            if (load && w >= 0) begin
                e.addr = req_addr[w];
                e.data = req_data[w];
                q.push_back(e);
                m_ptr    = (w + 1) % 4;
                m_cnt[w] = m_cnt[w] + 16'h1;
                for (int i = 0; i < 4; i++) begin
                    if (i == w) begin
                        m_wait[i] = 0;
                    end else if (req_valid[i]) begin
                        m_wait[i]++;
                        chk("starve_wait_le3", 64'(m_wait[i] <= 3), 64'(1));
                    end
                end
            end
            for (int i = 0; i < 4; i++) if (!req_valid[i]) m_wait[i] = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 4'b1111;
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 32'hA000_0000 + 32'(i);
            req_addr[i] = 8'h40 + 8'(i);
        end

        // Reset: no accept even with requests pending
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("rst_valid", 64'(bus.valid), 64'h0);
        chk("rst_data", 64'(bus.data), 64'h0);
        chk("rst_cnt", 64'(grant_cnt), 64'h0);

        // All requesters valid, sink always ready: strict rotation
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_order", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            if (c > 0) chk("rr_out_addr", 64'(bus.addr), 64'(8'h40 + 8'((c - 1) % 4)));
            next_cycle();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("rr_cnt_2each", 64'(grant_cnt[i]), 64'd2);
        chk("rr_last_addr", 64'(bus.addr), 64'h43);
        next_cycle();

        // Req 2 write, then sink stalls 5 cycles
        req_addr[2] = 8'h10;
        req_data[2] = 32'hDEADBEEF;
        req_valid   = 4'b0100;
        bus.ready   = 1'b0;
        @(negedge clk);
        chk("stall_accept", 64'(req_ready), 64'b0100);
        next_cycle();
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.valid), 64'h1);
            chk("stall_addr", 64'(bus.addr), 64'h10);
            chk("stall_data", 64'(bus.data), 64'hDEADBEEF);
            chk("stall_ready0", 64'(req_ready), 64'h0);
            next_cycle();
        end
        req_valid = 4'b0000;
        bus.ready = 1'b1;
        @(negedge clk);
        chk("release_data", 64'(bus.data), 64'hDEADBEEF);
        next_cycle();

        // Pointer at 3, only req 1 valid: accepted immediately, pointer -> 2
        req_valid = 4'b0010;
        @(negedge clk);
        chk("drained", 64'(bus.valid), 64'h0);
        chk("ptr3_req1", 64'(req_ready), 64'b0010);
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ptr2_pick", 64'(req_ready), 64'b0100);
        chk("req1_out", 64'(bus.addr), 64'h41);
        next_cycle();

        // Reset while holding a stalled write
        req_valid = 4'b0001;
        bus.ready = 1'b0;
        @(negedge clk);
        chk("full_stall", 64'(bus.valid), 64'h1);
        next_cycle();
        rstn      = 1'b0;
        bus.ready = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_comb_ready", 64'(req_ready), 64'h0);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_full_valid", 64'(bus.valid), 64'h0);
        chk("rst_full_cnt", 64'(grant_cnt), 64'h0);
        chk("rst_ptr0", 64'(req_ready), 64'b0001);

        // Counter wrap on requester 0
        next_cycle();
        req_valid = 4'b0001;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("cnt_ffff", 64'(grant_cnt[0]), 64'hFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("cnt_wrap", 64'(grant_cnt[0]), 64'h0);
        chk("cnt_other", 64'(grant_cnt[1]), 64'h0);

        // Random traffic
        next_cycle();
        for (int c = 0; c < 10000; c++) begin
            req_valid = 4'($urandom);
            bus.ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                req_data[i] = $urandom;
                req_addr[i] = 8'($urandom);
            end
            next_cycle();
        end
        req_valid = 4'b0000;
        bus.ready = 1'b1;
        repeat (3) next_cycle();
        chk("sb_empty", 64'(q.size()), 64'h0);
        chk("out_idle", 64'(bus.valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, register word width.
REQ-003 Parameter ADDR_WIDTH, default 8, register address width (matches 256-deep register RAM).
REQ-004 Port clk  input  1  single clock; all logic on posedge.
REQ-005 Port rstn  input  1  reset, synchronous, active-low.
REQ-006 Port req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-007 Port req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester write address.
REQ-008 Port req_valid  input  NUM_REQ  per-requester write request.
REQ-009 Port req_ready  output  NUM_REQ  per-requester accept, at most one bit high per cycle.
REQ-010 Port w_out  w_busif.master  data/addr/valid out, ready in  merged write stream toward the register controller's write port.
REQ-011 Port grant_cnt  output  NUM_REQ x 16  per-requester accepted-write counters.

Function
REQ-012 Transfer on requester i SHALL occur when req_valid[i] & req_ready[i]; on w_out when valid & ready.
REQ-013 Single output register (data, addr, valid, src index); load_en = ~w_out.valid | w_out.ready.
REQ-014 States: EMPTY (w_out.valid=0), FULL (w_out.valid=1); EMPTY->FULL on load; FULL->EMPTY on output transfer without load; FULL->FULL on output transfer with load or on stall.
REQ-015 Winner: first i with req_valid[i] searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
REQ-016 req_ready[winner] = load_en & rstn; all other req_ready bits 0; req_ready combinational from req_valid/w_out.ready.
REQ-017 Latency: accepted request appears on w_out the next cycle; sustained throughput one write per cycle when w_out.ready held high.
REQ-018 While w_out.valid & ~w_out.ready, w_out data/addr/valid SHALL hold stable and all req_ready SHALL be 0.
REQ-019 After accepting from i, rr_ptr <= (i+1) mod NUM_REQ; rr_ptr unchanged on cycles without acceptance.
REQ-020 No requester with continuous req_valid SHALL wait more than NUM_REQ-1 accepted transfers of others.
REQ-021 Requester dropping req_valid before handshake SHALL lose nothing; no request is latched without handshake.
REQ-022 grant_cnt[i] increments by 1 on each requester-i transfer, wraps 0xFFFF -> 0.
REQ-023 No req_valid high: w_out drains normally, rr_ptr and counters unchanged.

Reset
REQ-024 rstn low at posedge: w_out.valid=0, data=0, addr=0, rr_ptr=0, grant_cnt all 0, state EMPTY.
REQ-025 req_ready all 0 while rstn low, including combinationally; reset mid-transfer discards the held write.

Structure
REQ-026 Shared package reg_arb_pkg holds NUM_REQ default, GRANT_CNT_WIDTH=16, and the state enum {EMPTY, FULL}.
REQ-027 One sub-module rr_pick (combinational round-robin priority picker: req vector + pointer -> one-hot grant + index).
REQ-028 w_busif interface definition reused unchanged.

Verification
REQ-029 All 4 valid continuously, w_out.ready=1 -> accept order 0,1,2,3,0,...; one w_out transfer per cycle; grant_cnt equal after 8 cycles (2 each).
REQ-030 Req 2 sends addr 0x10 data 0xDEADBEEF, w_out.ready=0 for 5 cycles -> w_out holds 0x10/0xDEADBEEF, all req_ready 0; released on cycle ready rises.
REQ-031 rr_ptr=3, only req 1 valid -> req 1 accepted same cycle, rr_ptr becomes 2.
REQ-032 grant_cnt[0] preloaded near 0xFFFF via 65536 transfers -> wraps to 0 on 65536th transfer.
REQ-033 rstn low while FULL (w_out.valid=1, ready=0) -> next cycle w_out.valid=0, req_ready 0, counters 0, rr_ptr 0.
REQ-034 Random valid/ready stimulus, 10k cycles -> scoreboard: every accepted request appears exactly once, in acceptance order, no requester waits >3 grants.
